// File: rtl/snoop_cache_node.sv
// Direct-mapped MSI snooping cache node. It sits between one CPU front end
// and the shared snoop bus. It holds one data word per line, keeps
// saturating hit/miss counters, and exposes its controller state on fsm_state.
//
// Handshakes:
//   - CPU request: a transfer happens on a rising edge where cpu_req_valid
//     and cpu_req_ready are both 1. cpu_req_ready is 1 only in IDLE. The
//     request is latched on that edge. cpu_resp_valid is a one-cycle pulse
//     with no back-pressure.
//   - Bus ownership: bus_req is held until a cycle with bus_gnt=1 is used for
//     the node's own message. The message then appears, registered, for
//     exactly one cycle on bus_out_*.
//   - A snoop reply (RETURN or WB) uses the following cycle without
//     arbitration and takes priority over the node's own message. A grant
//     that collides with a snoop reply is not consumed, and bus_req stays
//     high.
module snoop_cache_node #(
    parameter int CPU_ID = 0,
    parameter int ID_W   = 2,
    parameter int IDX_W  = 2,
    parameter int TAG_W  = 1,
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_req_valid,
    input  logic                   cpu_req_we,
    input  logic [IDX_W+TAG_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0]      cpu_req_wdata,
    output logic                   cpu_req_ready,
    output logic                   cpu_resp_valid,
    output logic [DATA_W-1:0]      cpu_resp_rdata,
    output logic                   cpu_resp_hit,
    output logic                   bus_req,
    input  logic                   bus_gnt,
    output logic                   bus_out_valid,
    output logic [1:0]             bus_out_cmd,
    output logic [ID_W-1:0]        bus_out_id,
    output logic [IDX_W+TAG_W-1:0] bus_out_addr,
    output logic [DATA_W-1:0]      bus_out_data,
    input  logic                   bus_in_valid,
    input  logic [1:0]             bus_in_cmd,
    input  logic [ID_W-1:0]        bus_in_id,
    input  logic [IDX_W+TAG_W-1:0] bus_in_addr,
    input  logic [DATA_W-1:0]      bus_in_data,
    output logic [CNT_W-1:0]       hit_count,
    output logic [CNT_W-1:0]       miss_count,
    output logic [2:0]             fsm_state
);

    localparam int ADDR_W = IDX_W + TAG_W;
    localparam int LINES  = 1 << IDX_W;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    localparam logic [1:0] CMD_WB  = 2'b00;
    localparam logic [1:0] CMD_RM  = 2'b01;
    localparam logic [1:0] CMD_INV = 2'b10;
    localparam logic [1:0] CMD_RET = 2'b11;

    localparam logic [ID_W-1:0] MY_ID = ID_W'(CPU_ID);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WB_REQ   = 3'd1,
        MISS_REQ = 3'd2,
        WAIT_RET = 3'd3,
        RESP     = 3'd4
    } fsm_t;

    fsm_t state, next_state;

    // Line storage
    logic [1:0]        line_st   [LINES];
    logic [TAG_W-1:0]  line_tag  [LINES];
    logic [DATA_W-1:0] line_data [LINES];

    // Latched request and response
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] resp_data;
    logic              resp_hit;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    assign req_idx = req_addr[IDX_W-1:0];
    assign req_tag = req_addr[ADDR_W-1:IDX_W];

    // Snoop decode
    logic [IDX_W-1:0] sn_idx;
    logic [TAG_W-1:0] sn_tag;
    logic             sn_foreign;
    logic             sn_line_hit;
    logic             sn_blocked;
    logic             snoop_upd;
    logic [1:0]       snoop_new_st;
    logic             snoop_reply;
    logic [1:0]       reply_cmd;
    logic [ID_W-1:0]  reply_id;

    assign sn_idx      = bus_in_addr[IDX_W-1:0];
    assign sn_tag      = bus_in_addr[ADDR_W-1:IDX_W];
    assign sn_foreign  = bus_in_valid && (bus_in_id != MY_ID);
    assign sn_line_hit = (line_st[sn_idx] != ST_I) && (line_tag[sn_idx] == sn_tag);
    // While a fill is pending, the line being filled ignores invalidates; the fill wins.
    assign sn_blocked  = (state == WAIT_RET) && (sn_idx == req_idx);

    // Decide what a foreign snoop does to its line and whether it needs a bus reply.
    always_comb begin
        snoop_upd    = 1'b0;
        snoop_new_st = line_st[sn_idx];
        snoop_reply  = 1'b0;
        reply_cmd    = CMD_WB;
        reply_id     = MY_ID;
        if (sn_foreign && sn_line_hit) begin
            if (bus_in_cmd == CMD_RM && line_st[sn_idx] == ST_M) begin
                snoop_upd    = 1'b1;
                snoop_new_st = ST_S;
                snoop_reply  = 1'b1;
                reply_cmd    = CMD_RET;
                reply_id     = bus_in_id;
            end else if (bus_in_cmd == CMD_INV && !sn_blocked) begin
                snoop_upd    = 1'b1;
                snoop_new_st = ST_I;
                if (line_st[sn_idx] == ST_M) begin
                    snoop_reply = 1'b1;
                    reply_cmd   = CMD_WB;
                    reply_id    = MY_ID;
                end
            end
        end
    end

    // Lookup sees this cycle's snoop already applied, so a snooped victim is judged
    // by its post-snoop state.
    logic [IDX_W-1:0]  lk_idx;
    logic [1:0]        lk_st;
    logic [TAG_W-1:0]  lk_tag;
    logic [DATA_W-1:0] lk_data;
    logic              accept;
    logic              acc_hit;
    logic              acc_done;
    logic              own_send;
    logic              ret_match;

    // Line lookup for the incoming request (IDLE) or the latched one.
    always_comb begin
        lk_idx  = (state == IDLE) ? cpu_req_addr[IDX_W-1:0] : req_idx;
        lk_st   = (snoop_upd && sn_idx == lk_idx) ? snoop_new_st : line_st[lk_idx];
        lk_tag  = line_tag[lk_idx];
        lk_data = line_data[lk_idx];
    end

    assign accept    = cpu_req_valid && cpu_req_ready;
    assign acc_hit   = (lk_st != ST_I) && (lk_tag == cpu_req_addr[ADDR_W-1:IDX_W]);
    // A hit completes immediately unless it is a write to a shared line (upgrade).
    assign acc_done  = acc_hit && (!cpu_req_we || lk_st == ST_M);
    assign own_send  = bus_req && bus_gnt && !snoop_reply;
    assign ret_match = (state == WAIT_RET) && bus_in_valid && (bus_in_cmd == CMD_RET)
                       && (bus_in_id == MY_ID) && (bus_in_addr == req_addr);

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and bus request.
    always_comb begin
        next_state = state;
        bus_req    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (acc_done)            next_state = RESP;
                    else if (lk_st == ST_M)  next_state = WB_REQ;
                    else                     next_state = MISS_REQ;
                end
            end
            WB_REQ: begin
                // A snoop may already have cleaned the victim; skip the writeback then.
                if (lk_st != ST_M) begin
                    next_state = MISS_REQ;
                end else begin
                    bus_req = 1'b1;
                    if (bus_gnt && !snoop_reply) next_state = MISS_REQ;
                end
            end
            MISS_REQ: begin
                bus_req = 1'b1;
                if (bus_gnt && !snoop_reply) next_state = req_we ? RESP : WAIT_RET;
            end
            WAIT_RET: begin
                if (ret_match) next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign cpu_req_ready  = (state == IDLE);
    assign cpu_resp_valid = (state == RESP);
    assign cpu_resp_rdata = resp_data;
    assign cpu_resp_hit   = resp_hit;
    assign fsm_state      = state;

    // Line array, request latch and response data. The snoop update comes first
    // so that the node's own update of the same line takes precedence.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                line_st[i]   <= ST_I;
                line_tag[i]  <= '0;
                line_data[i] <= '0;
            end
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            resp_data <= '0;
            resp_hit  <= 1'b0;
        end else begin
            if (snoop_upd) line_st[sn_idx] <= snoop_new_st;
            if (accept) begin
                req_we    <= cpu_req_we;
                req_addr  <= cpu_req_addr;
                req_wdata <= cpu_req_wdata;
            end
            case (state)
                IDLE: begin
                    if (accept && acc_done) begin
                        if (cpu_req_we) line_data[lk_idx] <= cpu_req_wdata;
                        resp_data <= cpu_req_we ? cpu_req_wdata : lk_data;
                        resp_hit  <= 1'b1;
                    end
                end
                WB_REQ: begin
                    if (own_send) line_st[req_idx] <= ST_I;
                end
                MISS_REQ: begin
                    // A write covers the whole line, so it is installed without a fetch.
                    if (own_send && req_we) begin
                        line_st[req_idx]   <= ST_M;
                        line_tag[req_idx]  <= req_tag;
                        line_data[req_idx] <= req_wdata;
                        resp_data          <= req_wdata;
                        resp_hit           <= 1'b0;
                    end
                end
                WAIT_RET: begin
                    if (ret_match) begin
                        line_st[req_idx]   <= ST_S;
                        line_tag[req_idx]  <= req_tag;
                        line_data[req_idx] <= bus_in_data;
                        resp_data          <= bus_in_data;
                        resp_hit           <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered bus output; a snoop reply wins over the node's own message.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_out_valid <= 1'b0;
            bus_out_cmd   <= '0;
            bus_out_id    <= '0;
            bus_out_addr  <= '0;
            bus_out_data  <= '0;
        end else begin
            bus_out_valid <= 1'b0;
            bus_out_cmd   <= '0;
            bus_out_id    <= '0;
            bus_out_addr  <= '0;
            bus_out_data  <= '0;
            if (snoop_reply) begin
                bus_out_valid <= 1'b1;
                bus_out_cmd   <= reply_cmd;
                bus_out_id    <= reply_id;
                bus_out_addr  <= bus_in_addr;
                bus_out_data  <= line_data[sn_idx];
            end else if (own_send) begin
                bus_out_valid <= 1'b1;
                bus_out_id    <= MY_ID;
                if (state == WB_REQ) begin
                    bus_out_cmd  <= CMD_WB;
                    bus_out_addr <= {lk_tag, req_idx};
                    bus_out_data <= lk_data;
                end else begin
                    bus_out_cmd  <= req_we ? CMD_INV : CMD_RM;
                    bus_out_addr <= req_addr;
                end
            end
        end
    end

    // Saturating hit/miss counters, stepped once per completed CPU request.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == RESP) begin
            if (resp_hit) begin
                if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            end else begin
                if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_snoop_cache_node.sv
// Directed bench for snoop_cache_node. Expected CPU responses and bus
// messages are queued as stimulus is issued. A negedge monitor pops the
// queues and compares them whenever the node presents an output.
module tb_snoop_cache_node;

    localparam int ID_W   = 2;
    localparam int IDX_W  = 2;
    localparam int TAG_W  = 1;
    localparam int DATA_W = 3;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = IDX_W + TAG_W;

    localparam logic [1:0] WB  = 2'b00;
    localparam logic [1:0] RM  = 2'b01;
    localparam logic [1:0] INV = 2'b10;
    localparam logic [1:0] RET = 2'b11;

    logic              clk;
    logic              reset;
    logic              cpu_req_valid;
    logic              cpu_req_we;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [DATA_W-1:0] cpu_req_wdata;
    logic              cpu_req_ready;
    logic              cpu_resp_valid;
    logic [DATA_W-1:0] cpu_resp_rdata;
    logic              cpu_resp_hit;
    logic              bus_req;
    logic              bus_gnt;
    logic              bus_out_valid;
    logic [1:0]        bus_out_cmd;
    logic [ID_W-1:0]   bus_out_id;
    logic [ADDR_W-1:0] bus_out_addr;
    logic [DATA_W-1:0] bus_out_data;
    logic              bus_in_valid;
    logic [1:0]        bus_in_cmd;
    logic [ID_W-1:0]   bus_in_id;
    logic [ADDR_W-1:0] bus_in_addr;
    logic [DATA_W-1:0] bus_in_data;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;
    logic [2:0]        fsm_state;

    int total = 0;
    int bad   = 0;
    int exp_hits   = 0;
    int exp_misses = 0;

    logic [DATA_W:0]                  resp_exp_q[$];
    logic [2+ID_W+ADDR_W+DATA_W-1:0]  bus_exp_q[$];

    snoop_cache_node #(
        .CPU_ID(0), .ID_W(ID_W), .IDX_W(IDX_W), .TAG_W(TAG_W),
        .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_hit(cpu_resp_hit),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .bus_out_valid(bus_out_valid), .bus_out_cmd(bus_out_cmd),
        .bus_out_id(bus_out_id), .bus_out_addr(bus_out_addr),
        .bus_out_data(bus_out_data),
        .bus_in_valid(bus_in_valid), .bus_in_cmd(bus_in_cmd),
        .bus_in_id(bus_in_id), .bus_in_addr(bus_in_addr),
        .bus_in_data(bus_in_data),
        .hit_count(hit_count), .miss_count(miss_count),
        .fsm_state(fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s timed out", name);
    endtask

    // Scoreboard pushes with the saturating counter model
    task automatic exp_resp(input logic [DATA_W-1:0] d, input logic h);
        resp_exp_q.push_back({d, h});
        if (h) begin
            if (exp_hits < 255) exp_hits++;
        end else begin
            if (exp_misses < 255) exp_misses++;
        end
    endtask

    task automatic exp_bus(input logic [1:0] cmd, input logic [ID_W-1:0] id,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        bus_exp_q.push_back({cmd, id, addr, data});
    endtask

    // Driver tasks; each is entered and left at a falling edge
    task automatic cpu_req(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd);
        int n = 0;
        while (!cpu_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_req_ready) timeout("cpu_req_ready");
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wd;
        @(negedge clk);
        cpu_req_valid = 1'b0;
    endtask

    task automatic grant();
        int n = 0;
        while (!bus_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus_req) timeout("bus_req");
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
    endtask

    task automatic drive_bus(input logic [1:0] cmd, input logic [ID_W-1:0] id,
                             input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        bus_in_valid = 1'b1;
        bus_in_cmd   = cmd;
        bus_in_id    = id;
        bus_in_addr  = addr;
        bus_in_data  = data;
        @(negedge clk);
        bus_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cpu_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_req_ready) timeout("wait_idle");
    endtask

    task automatic check_counts(input string name);
        check({name, "_hits"}, 32'(hit_count), 32'(exp_hits));
        check({name, "_misses"}, 32'(miss_count), 32'(exp_misses));
    endtask

    // Monitor: compare every presented output against the queued expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_resp_valid) begin
                total++;
                if (resp_exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL resp_unexpected got rdata=%0h hit=%0b", cpu_resp_rdata, cpu_resp_hit);
                end else begin
                    logic [DATA_W:0] e;
                    e = resp_exp_q.pop_front();
                    if ({cpu_resp_rdata, cpu_resp_hit} !== e) begin
                        bad++;
                        $display("FAIL resp got rdata=%0h hit=%0b want rdata=%0h hit=%0b",
                                 cpu_resp_rdata, cpu_resp_hit, e[DATA_W:1], e[0]);
                    end
                end
            end
            if (bus_out_valid) begin
                total++;
                if (bus_exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL bus_unexpected got cmd=%0h id=%0h addr=%0h data=%0h",
                             bus_out_cmd, bus_out_id, bus_out_addr, bus_out_data);
                end else begin
                    logic [2+ID_W+ADDR_W+DATA_W-1:0] e;
                    e = bus_exp_q.pop_front();
                    if ({bus_out_cmd, bus_out_id, bus_out_addr, bus_out_data} !== e) begin
                        bad++;
                        $display("FAIL bus got cmd=%0h id=%0h addr=%0h data=%0h want %0h",
                                 bus_out_cmd, bus_out_id, bus_out_addr, bus_out_data, e);
                    end
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;
        bus_gnt       = 1'b0;
        bus_in_valid  = 1'b0;
        bus_in_cmd    = '0;
        bus_in_id     = '0;
        bus_in_addr   = '0;
        bus_in_data   = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready", 32'(cpu_req_ready), 32'd1);
        check("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_out_valid", 32'(bus_out_valid), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        check_counts("rst");
        reset = 1'b0;
        @(negedge clk);

        // Cold read miss of 0x1, filled with 5
        exp_bus(RM, 2'd0, 3'h1, 3'd0);
        exp_resp(3'd5, 1'b0);
        cpu_req(1'b0, 3'h1, 3'd0);
        grant();
        @(negedge clk);
        drive_bus(RET, 2'd0, 3'h1, 3'd5);
        wait_idle();
        check_counts("read_miss");

        // Read hit: response one cycle after acceptance
        exp_resp(3'd5, 1'b1);
        cpu_req(1'b0, 3'h1, 3'd0);
        check("hit_latency", 32'(cpu_resp_valid), 32'd1);
        wait_idle();
        check_counts("read_hit");

        // Write to a shared line upgrades with INVALIDATE, then read hit
        exp_bus(INV, 2'd0, 3'h1, 3'd0);
        exp_resp(3'd3, 1'b0);
        cpu_req(1'b1, 3'h1, 3'd3);
        grant();
        wait_idle();
        exp_resp(3'd3, 1'b1);
        cpu_req(1'b0, 3'h1, 3'd0);
        wait_idle();
        check_counts("upgrade");

        // Foreign READ_MISS on M line: RETURN to id 2, line drops to S
        exp_bus(RET, 2'd2, 3'h1, 3'd3);
        drive_bus(RM, 2'd2, 3'h1, 3'd0);
        @(negedge clk);
        exp_resp(3'd3, 1'b1);
        cpu_req(1'b0, 3'h1, 3'd0);
        wait_idle();
        // Foreign INVALIDATE on S line: silent, next read misses
        drive_bus(INV, 2'd2, 3'h1, 3'd0);
        @(negedge clk);
        exp_bus(RM, 2'd0, 3'h1, 3'd0);
        exp_resp(3'd3, 1'b0);
        cpu_req(1'b0, 3'h1, 3'd0);
        grant();
        drive_bus(RET, 2'd0, 3'h1, 3'd3);
        wait_idle();
        check_counts("snoop");

        // Make 0x1 modified, then write 0x5: WB victim, INVALIDATE, install M
        exp_bus(INV, 2'd0, 3'h1, 3'd0);
        exp_resp(3'd3, 1'b0);
        cpu_req(1'b1, 3'h1, 3'd3);
        grant();
        wait_idle();
        exp_bus(WB, 2'd0, 3'h1, 3'd3);
        exp_bus(INV, 2'd0, 3'h5, 3'd0);
        exp_resp(3'd6, 1'b0);
        cpu_req(1'b1, 3'h5, 3'd6);
        grant();
        grant();
        wait_idle();
        // Write hit in M updates in place without bus traffic
        exp_resp(3'd7, 1'b1);
        cpu_req(1'b1, 3'h5, 3'd7);
        wait_idle();
        exp_resp(3'd7, 1'b1);
        cpu_req(1'b0, 3'h5, 3'd0);
        wait_idle();
        check_counts("victim");

        // Grant collides with a snoop reply: RETURN first, own READ_MISS next grant
        exp_bus(RET, 2'd1, 3'h5, 3'd7);
        exp_bus(RM, 2'd0, 3'h2, 3'd0);
        exp_resp(3'd4, 1'b0);
        cpu_req(1'b0, 3'h2, 3'd0);
        bus_gnt = 1'b1;
        drive_bus(RM, 2'd1, 3'h5, 3'd0);
        bus_gnt = 1'b0;
        check("deferred_bus_req", 32'(bus_req), 32'd1);
        grant();
        drive_bus(RET, 2'd0, 3'h2, 3'd4);
        wait_idle();
        check_counts("collision");

        // Reset while waiting for a fill: nothing more on the bus, all lines I
        exp_bus(RM, 2'd0, 3'h3, 3'd0);
        cpu_req(1'b0, 3'h3, 3'd0);
        grant();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        drive_bus(RET, 2'd0, 3'h3, 3'd2);
        repeat (4) @(negedge clk);
        check("mid_rst_state", 32'(fsm_state), 32'd0);
        check("mid_rst_ready", 32'(cpu_req_ready), 32'd1);
        check_counts("mid_rst");
        // 0x5 was M before reset; now it must miss with no writeback
        exp_bus(RM, 2'd0, 3'h5, 3'd0);
        exp_resp(3'd1, 1'b0);
        cpu_req(1'b0, 3'h5, 3'd0);
        grant();
        drive_bus(RET, 2'd0, 3'h5, 3'd1);
        wait_idle();
        check_counts("post_rst");

        // Hit counter saturates at all-ones
        for (int i = 0; i < 260; i++) begin
            exp_resp(3'd1, 1'b1);
            cpu_req(1'b0, 3'h5, 3'd0);
        end
        wait_idle();
        check("hit_saturated", 32'(hit_count), 32'd255);
        check_counts("saturate");

        repeat (5) @(negedge clk);
        check("resp_q_empty", 32'(resp_exp_q.size()), 32'd0);
        check("bus_q_empty", 32'(bus_exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
